rv32i_mc_ctrl: RTL and testbench
================================

# rv32i_mc_ctrl

Multi-cycle control sequencer for the RV32I core. It fetches each instruction over a request/grant/valid instruction-memory port and classifies the opcode. It then steps the shared datapath (PC, IR, register file, ALU, data-memory port) through decode, execute, memory and writeback, one instruction at a time. It drives every datapath enable and mux select, counts retired instructions, and traps on illegal opcodes or memory timeouts.

## Interface
- `MEM_TIMEOUT`, default 255: maximum number of cycles spent waiting in a memory phase before a timeout trap.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction read data; sampled only when `imem_rvalid` is high in WAIT_IF.
- `imem_req` out 1 / `imem_gnt` in 1 / `imem_rvalid` in 1: instruction-fetch handshake.
- `dmem_req` out 1 / `dmem_we` out 1 / `dmem_gnt` in 1 / `dmem_rvalid` in 1: data-memory handshake; `rvalid` also acknowledges stores.
- `br_taken` in 1: ALU branch-compare result, valid in EXEC.
- `ir_we` out 1: IR load enable.
- `pc_we` out 1: PC load enable.
- `pc_sel` out 2: PC source. 0 = pc+4, 1 = pc+imm, 2 = ALU result (JALR); 3 is never driven.
- `rf_we` out 1: register-file write enable.
- `wb_sel` out 2: writeback source. 0 = ALU, 1 = load data, 2 = pc+4, 3 = imm.
- `alu_a_sel` out 1: ALU A operand. 0 = rs1, 1 = pc.
- `alu_b_sel` out 1: ALU B operand. 0 = rs2, 1 = imm.
- `trap` out 1: sticky trap flag.
- `trap_cause` out 2: 1 = illegal instruction, 2 = imem timeout, 3 = dmem timeout.
- `state` out 3: current FSM state, for debug.
- `instr_cnt` out 32: retired-instruction count.

## Operation
- **Opcode latch.** Holds a 7-bit opcode register, loaded from `instr[6:0]` in the same cycle `ir_we` is asserted.
- **Legal opcodes:** 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP. Everything else is illegal, including any `instr[1:0]` != 11.
- **RESET:** all outputs 0; goes to FETCH unconditionally.
- **FETCH:** `imem_req`=1, held until `imem_gnt` is sampled high, then WAIT_IF. `imem_rvalid` is ignored in this state.
- **WAIT_IF:** on `imem_rvalid`, assert `ir_we`=1, latch the opcode, go to DECODE.
- **DECODE:** single cycle for the register-file read. Illegal opcode → TRAP with cause 1; otherwise → EXEC.
- **EXEC** (operand selects and writes per class):
  - OP: `alu_a_sel`=0, `alu_b_sel`=0.
  - OP-IMM, LOAD, STORE, JALR: `alu_b_sel`=1.
  - AUIPC: `alu_a_sel`=1, `alu_b_sel`=1.
  - OP, OP-IMM, AUIPC: `rf_we`=1, `wb_sel`=0, `pc_we`=1, `pc_sel`=0.
  - LUI: `rf_we`=1, `wb_sel`=3, `pc_sel`=0.
  - JAL: `rf_we`=1, `wb_sel`=2, `pc_sel`=1.
  - JALR: `rf_we`=1, `wb_sel`=2, `pc_sel`=2.
  - BRANCH: `rf_we`=0, `pc_sel` = `br_taken` ? 1 : 0.
  - All of the above assert `pc_we`=1 and go to FETCH.
  - LOAD and STORE: no writes; go to MEM.
- **MEM:** `dmem_req`=1, `dmem_we`=1 for STORE, both held until `dmem_gnt`, then WAIT_MEM. `alu_b_sel` is held at 1 throughout MEM and WAIT_MEM.
- **WAIT_MEM:** on `dmem_rvalid`:
  - LOAD: `rf_we`=1, `wb_sel`=1.
  - STORE: `rf_we`=0.
  - Both: `pc_we`=1, `pc_sel`=0, go to FETCH.
- **TRAP:** `trap`=1 and `trap_cause` held. All enables and requests are 0. Absorbing; only `rst_n` leaves it.
- **Retirement:** a retire cycle is any cycle with `pc_we`=1. `instr_cnt` increments by 1 on each retire cycle and wraps from 0xFFFFFFFF to 0.
- **Timeout:** a cycle counter is cleared on entry to FETCH and to MEM. It counts every cycle spent in FETCH+WAIT_IF, or in MEM+WAIT_MEM.
  - If the counter equals `MEM_TIMEOUT` in a cycle where the awaited `gnt`/`rvalid` is low, go to TRAP with cause 2 (instruction side) or 3 (data side).
  - A `gnt`/`rvalid` arriving in that same cycle wins; no trap.

## Timing
- **Async reset:** state = RESET. `trap`, `trap_cause`, `instr_cnt`, the opcode register and the timeout counter are all 0; every output is 0.
- **Reset mid-transaction:** an outstanding request is abandoned and any later `rvalid` is ignored until the FSM is back in the matching wait state.
- **Output style:** all outputs are Moore/Mealy combinational from state, the opcode register and the current inputs; no registered output delay.
- **Minimum cycles per instruction** (gnt same cycle as req, rvalid the next cycle):
  - ALU, jump, branch, LUI, AUIPC: 4 (FETCH, WAIT_IF, DECODE, EXEC).
  - LOAD, STORE: 6.
- **Request rule:** `imem_req`/`dmem_req` never deassert before the grant is received. At most one request of each kind is outstanding at a time.
- **Memory ordering:** `rvalid` must arrive no earlier than the cycle after `gnt`.

## Test plan
- **Reset:** pulse `rst_n` low mid-WAIT_MEM. All outputs 0 while low; cycle 2 after release shows `imem_req`=1, and `instr_cnt`=0.
- **ADDI (0x00500093), zero-wait memory:** 4 cycles. In EXEC `rf_we`=1, `wb_sel`=0, `alu_b_sel`=1, `pc_sel`=0; `instr_cnt`=1 afterwards.
- **BEQ:** with `br_taken`=1, EXEC shows `pc_sel`=1, `rf_we`=0. With `br_taken`=0, EXEC shows `pc_sel`=0.
- **LW with `dmem_gnt` delayed 3 cycles:** `dmem_req` stays high 4 cycles. WAIT_MEM on `rvalid` shows `rf_we`=1, `wb_sel`=1, `pc_we`=1; total 9 cycles.
- **Illegal instruction 0x00000000:** DECODE → TRAP, `trap`=1, `trap_cause`=1. `imem_req` stays 0 for 20 further cycles.
- **Timeout with `MEM_TIMEOUT`=4:**
  - `imem_gnt` held low → TRAP with cause 2.
  - `gnt` arriving on the boundary cycle → no trap.
  - `dmem_rvalid` withheld on SW → cause 3.

Source files
------------

// File: rtl/rv32i_mc_ctrl_if.sv
// Request/grant/valid buses between the RV32I multi-cycle sequencer (master)
// and the instruction and data memories (slave).
interface rv32i_mc_ctrl_if;
    logic [31:0] instr;
    logic        imem_req;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_gnt;
    logic        dmem_rvalid;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  instr, imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output instr, imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid
    );
endinterface

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory and
// writeback over a shared datapath, with retire counting and trap handling.
module rv32i_mc_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rv32i_mc_ctrl_if.master        bus,
    input  logic                   br_taken,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic [1:0]             pc_sel,
    output logic                   rf_we,
    output logic [1:0]             wb_sel,
    output logic                   alu_a_sel,
    output logic                   alu_b_sel,
    output logic                   trap,
    output logic [1:0]             trap_cause,
    output logic [2:0]             state,
    output logic [31:0]            instr_cnt
);
    // Wide enough that a saturated counter sits above MEM_TIMEOUT and can
    // never match it again within the same memory phase.
    localparam int            TW        = $clog2(MEM_TIMEOUT + 2);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_IF  = 3'd2,
        S_DECODE   = 3'd3,
        S_EXEC     = 3'd4,
        S_MEM      = 3'd5,
        S_WAIT_MEM = 3'd6,
        S_TRAP     = 3'd7
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [6:0]    opcode_q;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    cause_q;
    logic          tmo_hit;
    logic          is_mem_op;
    logic          in_mem_phase;
    logic          tmo_clear;
    logic          unused_instr_bits;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    assign tmo_hit      = (tmo_cnt == TMO_LIMIT);
    assign is_mem_op    = (opcode_q == OP_LOAD) || (opcode_q == OP_STORE);
    assign in_mem_phase = (state_q == S_FETCH) || (state_q == S_WAIT_IF) ||
                          (state_q == S_MEM)   || (state_q == S_WAIT_MEM);
    assign tmo_clear    = ((state_d == S_FETCH) && (state_q != S_FETCH)) ||
                          ((state_d == S_MEM)   && (state_q != S_MEM));
    // Only the opcode field steers control; the rest belongs to the datapath.
    assign unused_instr_bits = ^bus.instr[31:7];

    assign state      = state_q;
    assign trap_cause = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (bus.imem_gnt)         state_d = S_WAIT_IF;
                        else if (tmo_hit)         state_d = S_TRAP;
            S_WAIT_IF:  if (bus.imem_rvalid)      state_d = S_DECODE;
                        else if (tmo_hit)         state_d = S_TRAP;
            S_DECODE:   state_d = is_legal(opcode_q) ? S_EXEC : S_TRAP;
            S_EXEC:     state_d = is_mem_op ? S_MEM : S_FETCH;
            S_MEM:      if (bus.dmem_gnt)         state_d = S_WAIT_MEM;
                        else if (tmo_hit)         state_d = S_TRAP;
            S_WAIT_MEM: if (bus.dmem_rvalid)      state_d = S_FETCH;
                        else if (tmo_hit)         state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        trap         = 1'b0;
        case (state_q)
            S_FETCH:   bus.imem_req = 1'b1;
            S_WAIT_IF: ir_we        = bus.imem_rvalid;
            S_EXEC: begin
                pc_we = !is_mem_op;
                case (opcode_q)
                    OP_OP:     rf_we = 1'b1;
                    OP_IMM:    begin rf_we = 1'b1; alu_b_sel = 1'b1; end
                    OP_AUIPC:  begin rf_we = 1'b1; alu_a_sel = 1'b1; alu_b_sel = 1'b1; end
                    OP_LUI:    begin rf_we = 1'b1; wb_sel = 2'd3; end
                    OP_JAL:    begin rf_we = 1'b1; wb_sel = 2'd2; pc_sel = 2'd1; end
                    OP_JALR:   begin rf_we = 1'b1; wb_sel = 2'd2; pc_sel = 2'd2; alu_b_sel = 1'b1; end
                    OP_BRANCH: pc_sel = br_taken ? 2'd1 : 2'd0;
                    OP_LOAD, OP_STORE: alu_b_sel = 1'b1;
                    default:   pc_we = 1'b0;
                endcase
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (opcode_q == OP_STORE);
                alu_b_sel    = 1'b1;
            end
            S_WAIT_MEM: begin
                alu_b_sel = 1'b1;
                if (bus.dmem_rvalid) begin
                    pc_we  = 1'b1;
                    rf_we  = (opcode_q == OP_LOAD);
                    wb_sel = (opcode_q == OP_LOAD) ? 2'd1 : 2'd0;
                end
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= 7'd0;
            instr_cnt <= 32'd0;
            tmo_cnt   <= '0;
            cause_q   <= 2'd0;
        end else begin
            if (ir_we) opcode_q <= bus.instr[6:0];
            if (pc_we) instr_cnt <= instr_cnt + 32'd1;
            if (tmo_clear)                         tmo_cnt <= '0;
            else if (in_mem_phase && tmo_cnt != '1) tmo_cnt <= tmo_cnt + TW'(1);
            if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
                case (state_q)
                    S_DECODE:           cause_q <= 2'd1;
                    S_FETCH, S_WAIT_IF: cause_q <= 2'd2;
                    default:            cause_q <= 2'd3;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Randomized self-checking bench for rv32i_mc_ctrl with a per-instruction
// behavioural model of cycle counts and datapath controls.
module tb_rv32i_mc_ctrl;
    localparam int TMO = 4;
    localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110111, 7'b0010111, 7'b1101111,
        7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] LW   = 32'h0000a183;
    localparam logic [31:0] SW   = 32'h0020a023;

    logic clk = 1'b0;
    logic rst_n;
    logic br_taken, ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel, trap;
    logic [1:0] pc_sel, wb_sel, trap_cause;
    logic [2:0] state;
    logic [31:0] instr_cnt;
    logic [49:0] outs;
    int checks = 0;
    int errors = 0;
    logic [31:0] model_cnt;

    always #5 clk = ~clk;

    rv32i_mc_ctrl_if bus();

    rv32i_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .br_taken(br_taken),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .trap(trap), .trap_cause(trap_cause), .state(state), .instr_cnt(instr_cnt)
    );

    assign outs = {ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_a_sel, alu_b_sel, trap,
                   trap_cause, state, instr_cnt, bus.imem_req, bus.dmem_req, bus.dmem_we};

    typedef struct {
        int cycles; bit retired; bit trapped; logic [1:0] cause;
        logic rf_we; logic [1:0] wb_sel; logic [1:0] pc_sel; logic a_sel; logic b_sel;
        int dreq_cycles; bit dwe_any; bit dwe_all; bit bsel_mem_all; int ir_we_cnt;
    } obs_t;

    typedef struct {
        bit legal; bit mem; bit store; logic rf_we; logic [1:0] wb_sel; logic [1:0] pc_sel;
        bit care_a; logic a_sel; bit care_b; logic b_sel;
    } exp_t;

    // Controls expected in the cycle that retires the instruction.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic bt);
        exp_t e;
        e = '{default: 0};
        e.legal = 1'b1;
        case (ins[6:0])
            7'b0110011: begin e.rf_we = 1; e.care_a = 1; e.care_b = 1; end
            7'b0010011: begin e.rf_we = 1; e.care_b = 1; e.b_sel = 1; end
            7'b0010111: begin e.rf_we = 1; e.care_a = 1; e.a_sel = 1; e.care_b = 1; e.b_sel = 1; end
            7'b0110111: begin e.rf_we = 1; e.wb_sel = 3; end
            7'b1101111: begin e.rf_we = 1; e.wb_sel = 2; e.pc_sel = 1; end
            7'b1100111: begin e.rf_we = 1; e.wb_sel = 2; e.pc_sel = 2; e.care_b = 1; e.b_sel = 1; end
            7'b1100011: e.pc_sel = bt ? 2'd1 : 2'd0;
            7'b0000011: begin e.mem = 1; e.rf_we = 1; e.wb_sel = 1; e.care_b = 1; e.b_sel = 1; end
            7'b0100011: begin e.mem = 1; e.store = 1; e.care_b = 1; e.b_sel = 1; end
            default:    e.legal = 1'b0;
        endcase
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
        bus.instr = 32'd0; br_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 32'd0;
    endtask

    // Acts as both memories with the given wait counts; returns at the retire or trap cycle.
    task automatic run_instr(input logic [31:0] ins, input int ig, input int ir,
                             input int dg, input int dr, input logic bt, output obs_t o);
        int ireq_n, dreq_n, iafter, dafter;
        ireq_n = 0; dreq_n = 0; iafter = -1; dafter = -1;
        o = '{default: 0};
        o.dwe_all = 1; o.bsel_mem_all = 1;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
            bus.instr = $urandom; br_taken = bt;
            #1;
            if (iafter >= 0) begin
                iafter++;
                if (iafter == ir + 1) begin bus.imem_rvalid = 1; bus.instr = ins; iafter = -1; end
            end
            if (dafter >= 0) begin
                dafter++;
                if (dafter == dr + 1) begin bus.dmem_rvalid = 1; dafter = -1; end
            end
            if (bus.imem_req) begin
                if (ireq_n == ig) begin bus.imem_gnt = 1; iafter = 0; end
                ireq_n++;
            end
            if (bus.dmem_req) begin
                if (dreq_n == dg) begin bus.dmem_gnt = 1; dafter = 0; end
                dreq_n++;
            end
            #1;
            if (trap) begin o.trapped = 1; o.cause = trap_cause; o.cycles = cyc; break; end
            if (ir_we) o.ir_we_cnt++;
            if (bus.dmem_req) begin
                o.dreq_cycles++;
                if (bus.dmem_we) o.dwe_any = 1; else o.dwe_all = 0;
            end
            if (dreq_n > 0 && !alu_b_sel) o.bsel_mem_all = 0;
            if (pc_we) begin
                o.retired = 1; o.cycles = cyc; o.rf_we = rf_we; o.wb_sel = wb_sel;
                o.pc_sel = pc_sel; o.a_sel = alu_a_sel; o.b_sel = alu_b_sel;
                break;
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
        bus.instr = 32'd0; br_taken = 1'b0;
        @(negedge clk); #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_initial outs=%h want 0", outs); end
        do_reset();
        run_instr(ADDI, 0, 0, 0, 0, 1'b0, o);
        // Walk a LW into WAIT_MEM by hand, then pulse reset there.
        @(negedge clk); bus.imem_gnt = 1; bus.imem_rvalid = 0; bus.dmem_rvalid = 0;
        @(negedge clk); bus.imem_gnt = 0; bus.imem_rvalid = 1; bus.instr = LW;
        @(negedge clk); bus.imem_rvalid = 0;
        @(negedge clk);
        @(negedge clk); bus.dmem_gnt = 1;
        @(negedge clk); bus.dmem_gnt = 0; #1;
        checks++;
        if ({alu_b_sel, bus.dmem_req, pc_we, instr_cnt} !== {1'b1, 1'b0, 1'b0, 32'd1}) begin
            errors++; $display("FAIL reset_pre_wait_mem got b=%b req=%b pcwe=%b cnt=%0d want 1 0 0 1",
                               alu_b_sel, bus.dmem_req, pc_we, instr_cnt);
        end
        #1 rst_n = 1'b0; #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_async outs=%h want 0", outs); end
        @(negedge clk); #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_held outs=%h want 0", outs); end
        rst_n = 1'b1; bus.dmem_rvalid = 1; #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_cycle1 outs=%h want 0", outs); end
        @(posedge clk); #1;
        checks++;
        if ({bus.imem_req, pc_we, instr_cnt} !== {1'b1, 1'b0, 32'd0}) begin
            errors++; $display("FAIL reset_cycle2 got req=%b pcwe=%b cnt=%0d want 1 0 0",
                               bus.imem_req, pc_we, instr_cnt);
        end
        model_cnt = 32'd0;
        run_instr(ADDI, 0, 0, 0, 0, 1'b0, o);
        model_cnt++;
        @(posedge clk); #1;
        checks++;
        if (o.retired !== 1'b1 || instr_cnt !== model_cnt) begin
            errors++; $display("FAIL reset_recover got ret=%b cnt=%0d want 1 %0d", o.retired, instr_cnt, model_cnt);
        end
    endtask

    task automatic test_addi();
        obs_t o;
        do_reset();
        run_instr(ADDI, 0, 0, 0, 0, 1'b0, o);
        model_cnt++;
        checks++; if (o.cycles !== 4 || !o.retired) begin errors++; $display("FAIL addi_cycles got %0d ret=%b want 4", o.cycles, o.retired); end
        checks++;
        if ({o.rf_we, o.wb_sel, o.b_sel, o.pc_sel} !== {1'b1, 2'd0, 1'b1, 2'd0}) begin
            errors++; $display("FAIL addi_exec got rf=%b wb=%0d b=%b pc=%0d want 1 0 1 0", o.rf_we, o.wb_sel, o.b_sel, o.pc_sel);
        end
        @(posedge clk); #1;
        checks++; if (instr_cnt !== 32'd1) begin errors++; $display("FAIL addi_cnt got %0d want 1", instr_cnt); end
    endtask

    task automatic test_branch();
        obs_t o;
        for (int t = 1; t >= 0; t--) begin
            run_instr(BEQ, 0, 0, 0, 0, t[0], o);
            checks++;
            if ({o.retired, o.rf_we, o.pc_sel} !== {1'b1, 1'b0, (t == 1) ? 2'd1 : 2'd0}) begin
                errors++; $display("FAIL beq_taken%0d got ret=%b rf=%b pc=%0d want 1 0 %0d", t, o.retired, o.rf_we, o.pc_sel, t);
            end
        end
    endtask

    task automatic test_load_delay();
        obs_t o;
        run_instr(LW, 0, 0, 3, 0, 1'b0, o);
        checks++; if (o.dreq_cycles !== 4) begin errors++; $display("FAIL lw_req_cycles got %0d want 4", o.dreq_cycles); end
        checks++; if (o.cycles !== 9 || !o.retired) begin errors++; $display("FAIL lw_cycles got %0d want 9", o.cycles); end
        checks++;
        if ({o.rf_we, o.wb_sel, o.bsel_mem_all, o.dwe_any} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL lw_wb got rf=%b wb=%0d bsel=%b we=%b want 1 1 1 0", o.rf_we, o.wb_sel, o.bsel_mem_all, o.dwe_any);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        bit bad;
        do_reset();
        run_instr(32'h00000000, 0, 0, 0, 0, 1'b0, o);
        checks++;
        if ({o.trapped, o.cause} !== {1'b1, 2'd1} || o.cycles !== 4) begin
            errors++; $display("FAIL illegal_trap got trap=%b cause=%0d cyc=%0d want 1 1 4", o.trapped, o.cause, o.cycles);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.imem_req || !trap || trap_cause != 2'd1 || pc_we || instr_cnt != 32'd0) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL illegal_absorb got leave=1 want 0"); end
        for (int n = 0; n < 5; n++) begin
            logic [31:0] ins;
            int ig, ir;
            do ins = $urandom; while (ref_model(ins, 1'b0).legal);
            ig = $urandom_range(0, 3); ir = $urandom_range(0, 3 - ig);
            do_reset();
            run_instr(ins, ig, ir, 0, 0, 1'b0, o);
            checks++;
            if ({o.trapped, o.cause} !== {1'b1, 2'd1} || o.cycles !== 4 + ig + ir) begin
                errors++; $display("FAIL illegal_rnd%0d ins=%h got trap=%b cause=%0d cyc=%0d want 1 1 %0d",
                                   n, ins, o.trapped, o.cause, o.cycles, 4 + ig + ir);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_reset();
        run_instr(ADDI, 1000, 0, 0, 0, 1'b0, o);
        checks++;
        if ({o.trapped, o.cause} !== {1'b1, 2'd2} || o.cycles !== TMO + 2) begin
            errors++; $display("FAIL tmo_gnt got trap=%b cause=%0d cyc=%0d want 1 2 %0d", o.trapped, o.cause, o.cycles, TMO + 2);
        end
        do_reset();
        run_instr(ADDI, 0, 1000, 0, 0, 1'b0, o);
        checks++;
        if ({o.trapped, o.cause} !== {1'b1, 2'd2} || o.cycles !== TMO + 2) begin
            errors++; $display("FAIL tmo_rvalid got trap=%b cause=%0d cyc=%0d want 1 2 %0d", o.trapped, o.cause, o.cycles, TMO + 2);
        end
        do_reset();
        run_instr(ADDI, TMO, 0, 0, 0, 1'b0, o);
        checks++;
        if ({o.retired, o.trapped} !== 2'b10 || o.cycles !== 4 + TMO) begin
            errors++; $display("FAIL tmo_gnt_edge got ret=%b trap=%b cyc=%0d want 1 0 %0d", o.retired, o.trapped, o.cycles, 4 + TMO);
        end
        run_instr(ADDI, 1, TMO - 2, 0, 0, 1'b0, o);
        checks++;
        if ({o.retired, o.trapped} !== 2'b10 || o.cycles !== 3 + TMO) begin
            errors++; $display("FAIL tmo_rvalid_edge got ret=%b trap=%b cyc=%0d want 1 0 %0d", o.retired, o.trapped, o.cycles, 3 + TMO);
        end
        run_instr(SW, 0, 0, 0, 1000, 1'b0, o);
        checks++;
        if ({o.trapped, o.cause} !== {1'b1, 2'd3} || o.cycles !== TMO + 6) begin
            errors++; $display("FAIL tmo_sw_rvalid got trap=%b cause=%0d cyc=%0d want 1 3 %0d", o.trapped, o.cause, o.cycles, TMO + 6);
        end
        checks++; if (instr_cnt !== 32'd2) begin errors++; $display("FAIL tmo_sw_cnt got %0d want 2", instr_cnt); end
        do_reset();
        run_instr(SW, 0, 0, 1000, 0, 1'b0, o);
        checks++;
        if ({o.trapped, o.cause} !== {1'b1, 2'd3} || o.cycles !== TMO + 6) begin
            errors++; $display("FAIL tmo_sw_gnt got trap=%b cause=%0d cyc=%0d want 1 3 %0d", o.trapped, o.cause, o.cycles, TMO + 6);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            int ig, ir, dg, dr, want_cyc;
            logic bt;
            exp_t e;
            obs_t o;
            ins = $urandom;
            ins[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
            ig = $urandom_range(0, 3); ir = $urandom_range(0, 3 - ig);
            dg = $urandom_range(0, 3); dr = $urandom_range(0, 3 - dg);
            bt = 1'($urandom_range(0, 1));
            e = ref_model(ins, bt);
            want_cyc = 4 + ig + ir + (e.mem ? 2 + dg + dr : 0);
            run_instr(ins, ig, ir, dg, dr, bt, o);
            checks++;
            if ({o.retired, o.trapped} !== 2'b10 || o.cycles !== want_cyc) begin
                errors++; $display("FAIL rnd%0d_cycles ins=%h got ret=%b trap=%b cyc=%0d want 1 0 %0d",
                                   n, ins, o.retired, o.trapped, o.cycles, want_cyc);
            end
            checks++;
            if ({o.rf_we, o.pc_sel} !== {e.rf_we, e.pc_sel}) begin
                errors++; $display("FAIL rnd%0d_ctrl ins=%h got rf=%b pc=%0d want %b %0d", n, ins, o.rf_we, o.pc_sel, e.rf_we, e.pc_sel);
            end
            if (e.rf_we) begin
                checks++;
                if (o.wb_sel !== e.wb_sel) begin errors++; $display("FAIL rnd%0d_wb ins=%h got %0d want %0d", n, ins, o.wb_sel, e.wb_sel); end
            end
            if (e.care_a) begin
                checks++;
                if (o.a_sel !== e.a_sel) begin errors++; $display("FAIL rnd%0d_asel ins=%h got %b want %b", n, ins, o.a_sel, e.a_sel); end
            end
            if (e.care_b) begin
                checks++;
                if (o.b_sel !== e.b_sel) begin errors++; $display("FAIL rnd%0d_bsel ins=%h got %b want %b", n, ins, o.b_sel, e.b_sel); end
            end
            checks++;
            if (o.dreq_cycles !== (e.mem ? dg + 1 : 0) || o.ir_we_cnt !== 1) begin
                errors++; $display("FAIL rnd%0d_hs ins=%h got dreq=%0d irwe=%0d want %0d 1", n, ins, o.dreq_cycles, o.ir_we_cnt, e.mem ? dg + 1 : 0);
            end
            if (e.mem) begin
                checks++;
                if ({o.dwe_any, o.dwe_all, o.bsel_mem_all} !== {e.store, e.store, 1'b1}) begin
                    errors++; $display("FAIL rnd%0d_mem ins=%h got we=%b%b bsel=%b want %b%b 1",
                                       n, ins, o.dwe_any, o.dwe_all, o.bsel_mem_all, e.store, e.store);
                end
            end
            model_cnt++;
            @(posedge clk); #1;
            checks++;
            if (instr_cnt !== model_cnt) begin errors++; $display("FAIL rnd%0d_cnt got %0d want %0d", n, instr_cnt, model_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_load_delay();
        test_illegal();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end
endmodule
